multi_user_lock_ctrl: RTL

//  Parametrised, clocked successor to the 4-user 12-bit password lock. It keeps one rewritable password and one

---
 rtl/multi_user_lock_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/multi_user_lock_ctrl.sv
// multi_user_lock_ctrl: per-user password lock with timed grant, lockout alarm and password change
module multi_user_lock_ctrl #(
  parameter int PASS_W = 12,
  parameter int NUM_USERS = 4,
  parameter int USER_W = $clog2(NUM_USERS),
  parameter int MAX_TRIES = 3,
  parameter int ACCESS_CYC = 8,
  parameter int LOCKOUT_CYC = 16,
  parameter logic [NUM_USERS*PASS_W-1:0] INIT_PASS = {12'h111, 12'hE93, 12'hF2A, 12'hAB3}
) (
  input  logic clk,
  input  logic reset,
  input  logic Enter,
  input  logic [USER_W-1:0] User,
  input  logic [PASS_W-1:0] InputPass,
  input  logic ChangeReq,
  output logic Access,
  output logic Alarm,
  output logic PassChanged,
  output logic [$clog2(MAX_TRIES+1)-1:0] Count,
  output logic [USER_W-1:0] ActiveUser
);
  localparam int CW = $clog2(MAX_TRIES + 1);
  localparam int TMAX = ACCESS_CYC > LOCKOUT_CYC ? ACCESS_CYC : LOCKOUT_CYC;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam logic [CW-1:0] MAXC = CW'(MAX_TRIES);
  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic [PASS_W-1:0] pass [NUM_USERS];
  logic [CW-1:0] cnt [NUM_USERS];
  logic valid, match;
  assign valid = {1'b0, User} < (USER_W+1)'(NUM_USERS);
  assign match = valid && pass[User] == InputPass;
  assign Count = valid ? cnt[User] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      Access <= 1'b0;
      Alarm <= 1'b0;
      PassChanged <= 1'b0;
      ActiveUser <= '0;
      timer <= '0;
      for (int i = 0; i < NUM_USERS; i++) begin
        cnt[i] <= '0;
        pass[i] <= INIT_PASS[i*PASS_W +: PASS_W];
      end
    end else begin
      PassChanged <= 1'b0;
      case (state)
        IDLE: if (Enter && valid) begin
          if (match) begin
            state <= GRANT;
            Access <= 1'b1;
            timer <= TW'(ACCESS_CYC - 1);
            cnt[User] <= '0;
            ActiveUser <= User;
          end else if (cnt[User] == MAXC - CW'(1)) begin
            state <= LOCKED;
            Alarm <= 1'b1;
            timer <= TW'(LOCKOUT_CYC - 1);
            cnt[User] <= MAXC;
            ActiveUser <= User;
          end else
            cnt[User] <= cnt[User] + CW'(1);
        end
        // a change strobe wins even on the final grant cycle
        GRANT: if (Enter && ChangeReq) begin
          pass[ActiveUser] <= InputPass;
          PassChanged <= 1'b1;
          state <= IDLE;
          Access <= 1'b0;
          timer <= '0;
        end else if (timer == '0) begin
          state <= IDLE;
          Access <= 1'b0;
        end else
          timer <= timer - TW'(1);
        LOCKED: if (timer == '0) begin
          state <= IDLE;
          Alarm <= 1'b0;
          cnt[ActiveUser] <= '0;
        end else
          timer <= timer - TW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule
